// File: rtl/tft_ili9341_spi_wrapper_pkg.sv
// rtl/tft_ili9341_spi_wrapper_pkg.sv - shared word layout constants and divider helper
package tft_ili9341_spi_wrapper_pkg;
    localparam int   SPI_WORD_W = 9;
    localparam int   DC_BIT     = 8;
    localparam logic DC_CMD     = 1'b0;
    localparam logic DC_DATA    = 1'b1;

    // A zero divider would never terminate a phase, so it is promoted to one.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction
endpackage

// File: rtl/tft_ili9341_spi_wrapper_spi_master_byte.sv
// rtl/tft_ili9341_spi_wrapper_spi_master_byte.sv - SCK divider and MSB-first mode 0 byte shifter
module spi_master_byte
    import tft_ili9341_spi_wrapper_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd2
) (
    input  logic       spiClk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       sck,
    output logic       sdi,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SHIFT_LOW  = 2'd1;
    localparam logic [1:0] SHIFT_HIGH = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    localparam logic [15:0] DIV_LAST = eff_div(CLK_DIV) - 16'd1;

    logic [1:0]  state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic [15:0] div_cnt;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge spiClk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
            div_cnt <= 16'd0;
            sck     <= 1'b0;
            sdi     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= tx_byte;
                        sdi     <= tx_byte[7];
                        bit_idx <= 3'd7;
                        div_cnt <= 16'd0;
                        state   <= SHIFT_LOW;
                    end
                end
                SHIFT_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 16'd0;
                        sck     <= 1'b1;
                        state   <= SHIFT_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                SHIFT_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 16'd0;
                        sck     <= 1'b0;
                        // Next bit is presented on the falling edge so it is settled before the next rise.
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            sdi     <= shreg[bit_idx - 3'd1];
                            state   <= SHIFT_LOW;
                        end else begin
                            state   <= DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/tft_ili9341_spi_wrapper.sv
// rtl/tft_ili9341_spi_wrapper.sv - ILI9341 byte writer: DC latch, CS framing and idle handshake
module tft_ili9341_spi_wrapper
    import tft_ili9341_spi_wrapper_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd2
) (
    input  logic                  spiClk,
    input  logic                  reset,
    input  logic [SPI_WORD_W-1:0] data,
    input  logic                  dataAvailable,
    output logic                  tft_sck,
    output logic                  tft_sdi,
    output logic                  tft_dc,
    output logic                  tft_cs,
    output logic                  idle
);
    logic start;
    logic spi_busy;
    logic spi_done;

    // Strobes arriving while a byte is in flight are dropped, not queued.
    assign start = dataAvailable && idle && !spi_busy;

    spi_master_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_master_byte (
        .spiClk  (spiClk),
        .reset   (reset),
        .start   (start),
        .tx_byte (data[7:0]),
        .sck     (tft_sck),
        .sdi     (tft_sdi),
        .busy    (spi_busy),
        .done    (spi_done)
    );

    always_ff @(posedge spiClk or posedge reset) begin
        if (reset) begin
            tft_dc <= DC_CMD;
            tft_cs <= 1'b1;
            idle   <= 1'b1;
        end else if (start) begin
            tft_dc <= data[DC_BIT];
            tft_cs <= 1'b0;
            idle   <= 1'b0;
        end else if (spi_done) begin
            tft_cs <= 1'b1;
            idle   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tft_ili9341_spi_wrapper.sv
// tb/tb_tft_ili9341_spi_wrapper.sv - self-checking bench for tft_ili9341_spi_wrapper
module tb_tft_ili9341_spi_wrapper;
    logic       spi_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [8:0] data_v [3];
    logic [2:0] dav_v;
    logic [2:0] sck_v, sdi_v, dc_v, cs_v, idle_v;

    int checks   = 0;
    int failures = 0;

    // Effective SCK half-period of each instance (CLK_DIV 1, 3 and 0).
    int div_tab [3] = '{1, 3, 1};

    always #5 spi_clk = ~spi_clk;

    tft_ili9341_spi_wrapper #(.CLK_DIV(16'd1)) dut0 (
        .spiClk(spi_clk), .reset(reset), .data(data_v[0]), .dataAvailable(dav_v[0]),
        .tft_sck(sck_v[0]), .tft_sdi(sdi_v[0]), .tft_dc(dc_v[0]), .tft_cs(cs_v[0]), .idle(idle_v[0]));
    tft_ili9341_spi_wrapper #(.CLK_DIV(16'd3)) dut1 (
        .spiClk(spi_clk), .reset(reset), .data(data_v[1]), .dataAvailable(dav_v[1]),
        .tft_sck(sck_v[1]), .tft_sdi(sdi_v[1]), .tft_dc(dc_v[1]), .tft_cs(cs_v[1]), .idle(idle_v[1]));
    tft_ili9341_spi_wrapper #(.CLK_DIV(16'd0)) dut2 (
        .spiClk(spi_clk), .reset(reset), .data(data_v[2]), .dataAvailable(dav_v[2]),
        .tft_sck(sck_v[2]), .tft_sdi(sdi_v[2]), .tft_dc(dc_v[2]), .tft_cs(cs_v[2]), .idle(idle_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one word on instance k, starting and ending on a negedge, and compares the
    // observed pin waveform against the ideal mode 0 frame for that word.
    task automatic run_byte(input int k, input logic [8:0] word, input bit glitch, input int gap);
        int d = div_tab[k];
        int busy = 0;
        int rises = 0;
        int sck_err = 0, sdi_err = 0, stab_err = 0, cs_err = 0, dc_err = 0;
        logic [7:0] rx = 8'd0;
        logic prev_sck = 1'b0, prev_sdi = 1'b0;
        logic exp_sck, exp_sdi;
        repeat (gap) @(negedge spi_clk);
        check("idle_before", idle_v[k], 1'b1);
        data_v[k] = word;
        dav_v[k]  = 1'b1;
        @(negedge spi_clk);
        dav_v[k]  = 1'b0;
        data_v[k] = 9'($urandom);
        for (int i = 0; i < 400 && idle_v[k] == 1'b0; i++) begin
            exp_sck = (i < 16 * d) ? 1'((i / d) % 2) : 1'b0;
            exp_sdi = (i < 16 * d) ? word[7 - i / (2 * d)] : word[0];
            if (sck_v[k] !== exp_sck) sck_err++;
            if (sdi_v[k] !== exp_sdi) sdi_err++;
            if (cs_v[k] !== 1'b0) cs_err++;
            if (dc_v[k] !== word[8]) dc_err++;
            if (!prev_sck && sck_v[k]) begin
                rises++;
                rx = {rx[6:0], sdi_v[k]};
                if (sdi_v[k] !== prev_sdi) stab_err++;
            end
            prev_sck = sck_v[k];
            prev_sdi = sdi_v[k];
            if (glitch && i == 5) begin
                data_v[k] = 9'h0FF;
                dav_v[k]  = 1'b1;
            end else begin
                dav_v[k]  = 1'b0;
            end
            busy++;
            @(negedge spi_clk);
        end
        dav_v[k] = 1'b0;
        check("busy_cycles", busy, 16 * d + 1);
        check("rx_byte", rx, word[7:0]);
        check("sck_rises", rises, 8);
        check("sck_shape", sck_err, 0);
        check("sdi_shape", sdi_err + stab_err, 0);
        check("cs_low_frame", cs_err, 0);
        check("dc_frame", dc_err, 0);
        check("cs_after", cs_v[k], 1'b1);
        check("idle_after", idle_v[k], 1'b1);
        check("dc_hold", dc_v[k], word[8]);
    endtask

    initial begin
        int quiet_err;
        int k;
        dav_v     = 3'b000;
        data_v[0] = 9'd0;
        data_v[1] = 9'd0;
        data_v[2] = 9'd0;
        repeat (3) @(negedge spi_clk);
        check("rst_sck", sck_v, 3'b000);
        check("rst_cs", cs_v, 3'b111);
        check("rst_idle", idle_v, 3'b111);
        reset = 1'b0;
        @(negedge spi_clk);

        run_byte(0, 9'h02A, 1'b0, 0);
        run_byte(1, 9'h1A5, 1'b0, 0);
        run_byte(1, 9'h155, 1'b1, 1);
        run_byte(0, 9'h02C, 1'b0, 2);
        run_byte(0, 9'h1F8, 1'b0, 0);
        run_byte(2, 9'h02A, 1'b0, 0);
        run_byte(2, 9'h1F8, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 2);
            run_byte(k, 9'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        // Abort a byte in flight with an asynchronous reset between clock edges.
        data_v[1] = 9'h1FF;
        dav_v[1]  = 1'b1;
        @(negedge spi_clk);
        dav_v[1]  = 1'b0;
        repeat (10) @(negedge spi_clk);
        check("pre_rst_busy", idle_v[1], 1'b0);
        @(posedge spi_clk);
        #3 reset = 1'b1;
        #1;
        check("arst_sck", sck_v, 3'b000);
        check("arst_sdi", sdi_v, 3'b000);
        check("arst_dc", dc_v, 3'b000);
        check("arst_cs", cs_v, 3'b111);
        check("arst_idle", idle_v, 3'b111);
        repeat (2) @(negedge spi_clk);
        reset = 1'b0;
        quiet_err = 0;
        repeat (20) begin
            @(negedge spi_clk);
            if (sck_v !== 3'b000 || idle_v !== 3'b111 || cs_v !== 3'b111) quiet_err++;
        end
        check("post_rst_quiet", quiet_err, 0);
        run_byte(1, 9'h0C3, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
